// File: rtl/ldw_exe_stage.sv
// rtl/ldw_exe_stage.sv - execute stage: ALU, result mux and iterative multiply/divide unit with HI/LO
module ldw_exe_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic        eshift,
    input  logic        ejal,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [31:0] eimm,
    input  logic [4:0]  ern,
    input  logic [31:0] epc4,
    input  logic [2:0]  emdop,
    output logic        e_stall,
    output logic        mwreg_i,
    output logic        mm2reg_i,
    output logic        mwmem_i,
    output logic [31:0] malu_i,
    output logic [31:0] mb_i,
    output logic [4:0]  mrn_i,
    output logic        md_busy
);

    typedef enum logic {IDLE, RUN} md_state_t;

    md_state_t   state;
    logic [5:0]  cnt;
    logic [31:0] hi, lo, opb;
    logic [63:0] acc;
    logic        is_div, neg_lo, neg_hi, dz;

    logic [31:0] op_a, op_b, alu_out;
    logic        md_op, md_start, signed_op;
    logic [31:0] mag_a, mag_b;

    assign op_a = eshift ? {27'b0, eimm[10:6]} : ea;
    assign op_b = ealuimm ? eimm : eb;

    always_comb begin
        alu_out = '0;
        casez (ealuc)
            4'b?000: alu_out = op_a + op_b;
            4'b?100: alu_out = op_a - op_b;
            4'b?001: alu_out = op_a & op_b;
            4'b?101: alu_out = op_a | op_b;
            4'b?010: alu_out = op_a ^ op_b;
            4'b?110: alu_out = op_b << 16;
            4'b0011: alu_out = op_b << op_a[4:0];
            4'b0111: alu_out = op_b >> op_a[4:0];
            4'b1111: alu_out = $signed(op_b) >>> op_a[4:0];
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        malu_i = alu_out;
        if (ejal)
            malu_i = epc4 + 32'd4;
        else if (emdop == 3'b101)
            malu_i = hi;
        else if (emdop == 3'b110)
            malu_i = lo;
    end

    assign md_busy  = (state == RUN);
    assign md_op    = (emdop >= 3'b001) && (emdop <= 3'b100);
    assign md_start = md_op && !md_busy;
    assign e_stall  = md_busy && (emdop != 3'b000) && (emdop != 3'b111);

    assign mwreg_i  = ewreg  && !e_stall;
    assign mm2reg_i = em2reg && !e_stall;
    assign mwmem_i  = ewmem  && !e_stall;
    assign mb_i     = eb;
    assign mrn_i    = ern;

    assign signed_op = (emdop == 3'b001) || (emdop == 3'b011);
    assign mag_a     = (signed_op && ea[31]) ? -ea : ea;
    assign mag_b     = (signed_op && eb[31]) ? -eb : eb;

    // One radix-2 step. Multiply: {acc_hi, multiplier} shift-add.
    // Divide: {remainder, quotient} restoring, quotient bits shift in at the bottom.
    logic [32:0] mul_sum, div_rs, div_trial;
    logic [63:0] acc_next, prod;
    logic [31:0] quo, rem;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        div_rs    = acc[63:31];
        div_trial = div_rs - {1'b0, opb};
        if (is_div)
            acc_next = div_trial[32] ? {div_rs[31:0], acc[30:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};
        else
            acc_next = {mul_sum, acc[31:1]};
        prod = neg_lo ? -acc_next : acc_next;
        quo  = neg_lo ? -acc_next[31:0] : acc_next[31:0];
        rem  = neg_hi ? -acc_next[63:32] : acc_next[63:32];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        acc    <= {32'b0, mag_a};
                        opb    <= mag_b;
                        is_div <= emdop[1] ^ emdop[0] ? 1'b0 : 1'b1;
                        neg_lo <= signed_op && (ea[31] ^ eb[31]);
                        neg_hi <= signed_op && ea[31];
                        dz     <= (eb == 32'd0);
                        cnt    <= 6'(MD_CYCLES);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        // Divide by zero keeps the natural remainder (the dividend) but forces all-ones quotient.
                        if (is_div) begin
                            lo <= dz ? 32'hFFFF_FFFF : quo;
                            hi <= rem;
                        end else begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldw_exe_stage.sv
// tb/tb_ldw_exe_stage.sv - scoreboard bench for ldw_exe_stage with arithmetic reference model
module tb_ldw_exe_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern;
    logic [2:0]  emdop;
    logic        e_stall, mwreg_i, mm2reg_i, mwmem_i, md_busy;
    logic [31:0] malu_i, mb_i;
    logic [4:0]  mrn_i;

    ldw_exe_stage #(.MD_CYCLES(32)) dut (
        .clk(clk), .clrn(clrn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
        .ea(ea), .eb(eb), .eimm(eimm), .ern(ern), .epc4(epc4), .emdop(emdop),
        .e_stall(e_stall), .mwreg_i(mwreg_i), .mm2reg_i(mm2reg_i), .mwmem_i(mwmem_i),
        .malu_i(malu_i), .mb_i(mb_i), .mrn_i(mrn_i), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        logic [2:0]  ctl;
        int          stalls;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic        inst_valid = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          busy_until = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = a[4:0];
        case (c)
            4'b0000, 4'b1000: return a + b;
            4'b0100, 4'b1100: return a - b;
            4'b0001, 4'b1001: return a & b;
            4'b0101, 4'b1101: return a | b;
            4'b0010, 4'b1010: return a ^ b;
            4'b0110, 4'b1110: return {b[15:0], 16'h0000};
            4'b0011:          return b << s;
            4'b0111:          return b >> s;
            4'b1111:          return 32'($signed(b) >>> s);
            default:          return 32'h0;
        endcase
    endfunction

    task automatic md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        int          ia, ib;
        case (op)
            3'b001: begin
                sa = longint'($signed(a)); sb = longint'($signed(b)); p = sa * sb;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'b010: begin
                up = {32'b0, a} * {32'b0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'b011: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin
                    ia = int'(a); ib = int'(b);
                    m_lo = 32'(ia / ib); m_hi = 32'(ia % ib);
                end
            end
            3'b100: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] c, input logic aimm, input logic sh, input logic jal,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc4, input logic [4:0] rn, input logic [2:0] mdop,
                         input logic [2:0] ctl);
        exp_t        e;
        int          start;
        logic [31:0] aa, bb;
        int          n;
        ealuc = c; ealuimm = aimm; eshift = sh; ejal = jal; ea = a; eb = b; eimm = imm;
        epc4 = pc4; ern = rn; emdop = mdop; {ewreg, em2reg, ewmem} = ctl;
        inst_valid = 1'b1;
        start = cyc;
        e.stalls = 0;
        if (mdop >= 1 && mdop <= 6 && busy_until >= cyc) begin
            e.stalls = busy_until - cyc + 1;
            start = busy_until + 1;
        end
        aa = sh ? {27'b0, imm[10:6]} : a;
        bb = aimm ? imm : b;
        if (jal)             e.alu = pc4 + 32'd4;
        else if (mdop == 5)  e.alu = m_hi;
        else if (mdop == 6)  e.alu = m_lo;
        else                 e.alu = ref_alu(c, aa, bb);
        if (mdop >= 1 && mdop <= 4) begin
            md_model(mdop, a, b);
            busy_until = start + 32;
        end
        e.b = b; e.rn = rn; e.ctl = ctl;
        sbq.push_back(e);
        for (n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!e_stall) break;
        end
        if (n == 80) begin
            errors++;
            $display("FAIL stall_timeout: e_stall still %b after 80 cycles", e_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        inst_valid = 1'b0;
        emdop = 3'b000; ejal = 1'b0; {ewreg, em2reg, ewmem} = 3'b000;
    endtask

    int   stall_cnt = 0;
    logic stall_wr  = 1'b0;

    always @(negedge clk) begin
        if (inst_valid) begin
            if (e_stall) begin
                stall_cnt++;
                if (mwreg_i || mm2reg_i || mwmem_i) stall_wr = 1'b1;
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output presented with malu_i %h", malu_i);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("malu_i", malu_i, e.alu);
                chk("mb_i", mb_i, e.b);
                chk("mrn_i", {27'b0, mrn_i}, {27'b0, e.rn});
                chk("ctl", {29'b0, mwreg_i, mm2reg_i, mwmem_i}, {29'b0, e.ctl});
                chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                chk("stall_bubble", {31'b0, stall_wr}, 32'h0);
                stall_cnt = 0;
                stall_wr  = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] codes [15] = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h1, 4'h9, 4'h5, 4'hD,
                               4'h2, 4'hA, 4'h6, 4'hE, 4'h3, 4'h7, 4'hF};

    initial begin
        logic [2:0]  op;
        logic [31:0] rb;
        int          r;
        clrn = 1'b0;
        ewreg = 0; em2reg = 0; ewmem = 0; ealuc = 0; ealuimm = 0; eshift = 0; ejal = 0;
        ea = 0; eb = 0; eimm = 0; ern = 0; epc4 = 0; emdop = 3'b101;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_md_busy", {31'b0, md_busy}, 32'h0);
        chk("reset_e_stall", {31'b0, e_stall}, 32'h0);
        @(negedge clk) clrn = 1'b1;
        @(posedge clk); #1;

        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 3'b101, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd2, 3'b110, 3'b100);
        issue(4'h4, 0, 0, 0, 5, 9, 0, 0, 5'd3, 3'b000, 3'b100);
        issue(4'hF, 0, 1, 0, 0, 32'h8000_0000, 32'h0000_0100, 0, 5'd4, 3'b000, 3'b100);
        issue(4'h0, 0, 0, 1, 7, 8, 0, 32'h0040_0008, 5'd31, 3'b000, 3'b100);

        issue(4'h0, 0, 0, 0, -32'sd3, 32'd7, 0, 0, 5'd0, 3'b001, 3'b000);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 3'b101, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 3'b110, 3'b100);

        issue(4'h0, 0, 0, 0, -32'sd7, 32'd2, 0, 0, 5'd0, 3'b011, 3'b000);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 3'b110, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 3'b101, 3'b100);
        issue(4'h0, 0, 0, 0, 32'd7, 32'd0, 0, 0, 5'd0, 3'b100, 3'b000);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 3'b110, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd10, 3'b101, 3'b100);
        issue(4'h0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd0, 3'b011, 3'b000);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd11, 3'b110, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 3'b101, 3'b100);

        issue(4'h0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd0, 3'b010, 3'b000);
        for (int i = 0; i < 10; i++)
            issue(codes[i], 0, 0, 0, $urandom, $urandom, 0, 0, 5'(i), 3'b000, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd13, 3'b101, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd14, 3'b110, 3'b100);

        issue(4'h0, 0, 0, 0, 32'd1000, 32'd7, 0, 0, 5'd0, 3'b011, 3'b000);
        idle();
        repeat (8) begin @(posedge clk); #1; end
        emdop = 3'b110;
        #1;
        chk("busy_before_abort", {31'b0, e_stall}, 32'h1);
        clrn = 1'b0;
        #1;
        chk("abort_md_busy", {31'b0, md_busy}, 32'h0);
        chk("abort_e_stall", {31'b0, e_stall}, 32'h0);
        m_hi = '0; m_lo = '0; busy_until = -100;
        @(negedge clk) clrn = 1'b1;
        @(posedge clk); #1;
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd15, 3'b110, 3'b100);
        issue(4'h0, 0, 0, 0, 0, 0, 0, 0, 5'd16, 3'b101, 3'b100);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 3'b000 : (r == 6) ? 3'($urandom_range(1, 4)) :
                 (r == 7) ? 3'b101 : (r == 8) ? 3'b110 : 3'b111;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            issue(codes[$urandom_range(0, 14)], 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0), $urandom, rb, $urandom, $urandom,
                  5'($urandom), op, 3'($urandom));
        end

        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
